if_id_queue: RTL and testbench

Instruction queue between the fetch stage and the decode stage. Captures each fetched (PC, instruction) pair into a small FIFO and presents the oldest entry to decode through a valid/ready handshake. Its not-ready output is what drives the fetch stage's freeze input. A branch-taken flush discards every queued entry in one cycle.

---
 rtl/if_id_queue_pkg.sv | 17 +
 rtl/if_id_queue_if.sv | 27 ++
 rtl/ifq_storage.sv | 27 ++
 rtl/if_id_queue.sv | 102 ++++++++++
 tb/tb_if_id_queue.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared fetch/decode word width, NOP encoding and the queue entry type.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef NOP_INSTR
`define NOP_INSTR 32'd0
`endif

package if_id_queue_pkg;
  localparam int WORD_LEN = `WORD_LEN;
  localparam logic [WORD_LEN-1:0] NOP_INSTR = `NOP_INSTR;

  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] instr;
  } ifq_entry_t;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push and decode-side pop handshake of the instruction queue.
// The slave modport is the queue; the master modport is the fetch/decode side.
interface if_id_queue_if #(parameter int DEPTH = 4);
  import if_id_queue_pkg::*;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                in_valid;
  logic [WORD_LEN-1:0] in_pc;
  logic [WORD_LEN-1:0] in_instr;
  logic                in_ready;
  logic                flush;
  logic                out_valid;
  logic [WORD_LEN-1:0] out_pc;
  logic [WORD_LEN-1:0] out_instr;
  logic                out_ready;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, count
  );

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/ifq_storage.sv
// DEPTH-entry (PC, instr) register array: synchronous write, asynchronous read.
// No reset; occupancy tracking in the parent decides which entries are meaningful.
module ifq_storage
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  ifq_entry_t       wr_dat_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output ifq_entry_t       rd_dat_o
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction FIFO: 1-cycle latency, in_ready low while full (no pass-through), flush empties in one cycle.
// Defining IFQ_PERF_EN adds saturating flush_cnt / stall_cnt counters.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  if_id_queue_if.slave       bus
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready;
  logic             out_valid;
  logic             push;
  logic             pop;
  ifq_entry_t       wr_dat;
  ifq_entry_t       rd_dat;

  // Ready/valid come from registered occupancy only, so fetch freeze never sees decode stall combinationally.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid & in_ready & ~bus.flush;
  assign pop       = out_valid & bus.out_ready & ~bus.flush;

  assign wr_dat = '{pc: bus.in_pc, instr: bus.in_instr};

  ifq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk      (clk),
    .wr_en_i  (push),
    .wr_ptr_i (wr_ptr_q),
    .wr_dat_i (wr_dat),
    .rd_ptr_i (rd_ptr_q),
    .rd_dat_o (rd_dat)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? rd_dat.pc : '0;
  assign bus.out_instr = out_valid ? rd_dat.instr : NOP_INSTR;
  assign bus.count     = count_q;

`ifdef IFQ_PERF_EN
  logic [31:0] flush_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (bus.flush && out_valid && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (bus.in_valid && !in_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, randomized traffic against a queue model, async reset.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
`ifdef IFQ_PERF_EN
  logic [31:0] flush_cnt;
  logic [31:0] stall_cnt;
`endif

  if_id_queue_if #(.DEPTH(DEPTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef IFQ_PERF_EN
    ,
    .flush_cnt (flush_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: an ordered list of (pc, instr) words plus event counters.
  logic [63:0] mq[$];
  int          m_flush = 0;
  int          m_stall = 0;

  typedef struct {
    logic             v;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             fl;
    logic             ordy;
    logic [CNT_W-1:0] ec;
    logic             eov;
    logic [31:0]      epc;
    logic [31:0]      eins;
    logic             eir;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int sz;
    sz = mq.size();
    chk("count", 64'(bus.count), 64'(sz));
    chk("out_valid", 64'(bus.out_valid), 64'(sz != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(sz < DEPTH));
    chk("out_pc", 64'(bus.out_pc), (sz != 0) ? 64'(mq[0][63:32]) : 64'd0);
    chk("out_instr", 64'(bus.out_instr), (sz != 0) ? 64'(mq[0][31:0]) : 64'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 0;
    m_stall = 0;
  endtask

  // Drive one cycle of inputs, check outputs against the model, advance model and clock.
  task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic ordy);
    int sz;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    model_check();
    sz = mq.size();
    if (v && sz == DEPTH) m_stall++;
    if (fl) begin
      if (sz != 0) m_flush++;
      mq.delete();
    end else begin
      if (ordy && sz != 0) void'(mq.pop_front());
      if (v && sz < DEPTH) mq.push_back({pc, instr});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic fl, input logic ordy, input int ec, input logic eov,
                     input logic [31:0] epc, input logic [31:0] eins, input logic eir);
    vec_t e;
    e.v = v; e.pc = pc; e.instr = instr; e.fl = fl; e.ordy = ordy;
    e.ec = CNT_W'(ec); e.eov = eov; e.epc = epc; e.eins = eins; e.eir = eir;
    tbl.push_back(e);
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Expected state after each vector's clock edge.
    // Streaming, out_ready high
    add(1, 32'h0,   32'hA0, 0, 1, 1, 1, 32'h0,   32'hA0, 1);
    add(1, 32'h4,   32'hA1, 0, 1, 1, 1, 32'h4,   32'hA1, 1);
    add(1, 32'h8,   32'hA2, 0, 1, 1, 1, 32'h8,   32'hA2, 1);
    add(1, 32'hC,   32'hA3, 0, 1, 1, 1, 32'hC,   32'hA3, 1);
    add(0, 32'h0,   32'h0,  0, 1, 0, 0, 32'h0,   32'h0,  1);
    // Fill and backpressure
    add(1, 32'h100, 32'hB0, 0, 0, 1, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h104, 32'hB1, 0, 0, 2, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h108, 32'hB2, 0, 0, 3, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h10C, 32'hB3, 0, 0, 4, 1, 32'h100, 32'hB0, 0);
    add(1, 32'h110, 32'hB4, 0, 0, 4, 1, 32'h100, 32'hB0, 0);
    add(1, 32'h110, 32'hB4, 0, 1, 3, 1, 32'h104, 32'hB1, 1);
    add(1, 32'h110, 32'hB4, 0, 0, 4, 1, 32'h104, 32'hB1, 0);
    // Drain to count=2, then push+pop until write pointer wraps 3 -> 0
    add(0, 32'h0,   32'h0,  0, 1, 3, 1, 32'h108, 32'hB2, 1);
    add(0, 32'h0,   32'h0,  0, 1, 2, 1, 32'h10C, 32'hB3, 1);
    add(1, 32'h114, 32'hB5, 0, 1, 2, 1, 32'h110, 32'hB4, 1);
    add(1, 32'h118, 32'hB6, 0, 1, 2, 1, 32'h114, 32'hB5, 1);
    add(1, 32'h11C, 32'hB7, 0, 1, 2, 1, 32'h118, 32'hB6, 1);
    // Flush priority at count=3 with push and pop requested
    add(1, 32'h120, 32'hB8, 0, 0, 3, 1, 32'h118, 32'hB6, 1);
    add(1, 32'h124, 32'hB9, 1, 1, 0, 0, 32'h0,   32'h0,  1);
    add(1, 32'h128, 32'hBA, 0, 0, 1, 1, 32'h128, 32'hBA, 1);
    add(0, 32'h0,   32'h0,  0, 1, 0, 0, 32'h0,   32'h0,  1);
    add(1, 32'h12C, 32'hBB, 1, 0, 0, 0, 32'h0,   32'h0,  1);

    // Reset then idle
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_count", 64'(bus.count), 64'd0);
    rst = 1'b1;
    model_reset();
    apply(0, 32'h0, 32'h0, 0, 0);
    apply(0, 32'h0, 32'h0, 0, 1);

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].fl, tbl[i].ordy);
      chk($sformatf("vec%0d_count", i), 64'(bus.count), 64'(tbl[i].ec));
      chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].eov));
      chk($sformatf("vec%0d_out_pc", i), 64'(bus.out_pc), 64'(tbl[i].epc));
      chk($sformatf("vec%0d_out_instr", i), 64'(bus.out_instr), 64'(tbl[i].eins));
      chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].eir));
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      apply($urandom_range(99) < 70, 32'(n * 4), $urandom,
            $urandom_range(99) < 5, $urandom_range(99) < 55);
    end

`ifdef IFQ_PERF_EN
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

    // Async reset mid-stream at count=2
    apply(0, 32'h0, 32'h0, 1, 0);
    apply(1, 32'h200, 32'hC0, 0, 0);
    apply(1, 32'h204, 32'hC1, 0, 0);
    chk("pre_areset_count", 64'(bus.count), 64'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("areset_count", 64'(bus.count), 64'd0);
    chk("areset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("areset_out_instr", 64'(bus.out_instr), 64'd0);
    chk("areset_out_pc", 64'(bus.out_pc), 64'd0);
    chk("areset_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef IFQ_PERF_EN
    chk("areset_flush_cnt", 64'(flush_cnt), 64'd0);
    chk("areset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(1, 32'h300, 32'hD0, 0, 0);
    apply(0, 32'h0, 32'h0, 0, 1);
    apply(0, 32'h0, 32'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
